// File: rtl/frame_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_feeder_pkg : shared FSM state and FIFO entry types             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package frame_feeder_pkg;

  // Entry struct is sized for the widest supported sample; narrower
  // instances store only DATA_WIDTH+1 bits in the FIFO itself.
  localparam int unsigned FF_MAX_DATA_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_STREAM  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_REPORT  = 2'd3
  } ff_state_t;

  typedef struct packed {
    logic                         last;
    logic [FF_MAX_DATA_WIDTH-1:0] data;
  } ff_entry_t;

endpackage : frame_feeder_pkg
`default_nettype wire

// File: rtl/frame_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_fifo : small synchronous FIFO with occupancy-derived flags     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module frame_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int            c_ADDR_W = $clog2(DEPTH);
  localparam logic [c_ADDR_W:0] c_DEPTH = (c_ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == c_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule : frame_fifo
`default_nettype wire

// File: rtl/frame_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_feeder : buffers a sample stream into a second-largest tracker |
// | and reports the per-frame result with its sample count. Rev 1.0     |
// +----------------------------------------------------------------------+
module frame_feeder
  import frame_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  output logic [DATA_WIDTH-1:0]  trk_din,
  output logic                   trk_resetn,
  input  logic [DATA_WIDTH-1:0]  trk_dout,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [COUNT_WIDTH-1:0] m_count
);

  ff_state_t r_state;
  ff_state_t w_state_nxt;

  logic [DATA_WIDTH-1:0]  r_m_data;
  logic [COUNT_WIDTH-1:0] r_m_count;

  ff_entry_t             w_push_ent;
  ff_entry_t             w_head_ent;
  logic [DATA_WIDTH:0]   w_fifo_din;
  logic [DATA_WIDTH:0]   w_fifo_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;

  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_trk_din;
  logic                  w_trk_resetn;
  logic                  w_m_valid;
  logic                  w_cnt_clr;
  logic                  w_capture;

  // Gating with resetn keeps s_ready low for the whole reset interval.
  assign s_ready = resetn & ~w_fifo_full;
  assign w_push  = s_valid & s_ready;

  assign w_push_ent.last = s_last;
  assign w_push_ent.data = FF_MAX_DATA_WIDTH'(s_data);
  assign w_fifo_din      = {w_push_ent.last, DATA_WIDTH'(w_push_ent.data)};

  assign w_head_ent.last = w_fifo_head[DATA_WIDTH];
  assign w_head_ent.data = FF_MAX_DATA_WIDTH'(w_fifo_head[DATA_WIDTH-1:0]);

  frame_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_fifo_head)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_CLEAR;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR:   w_state_nxt = ST_STREAM;
      ST_STREAM:  if (!w_fifo_empty && w_head_ent.last) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_REPORT;
      ST_REPORT:  if (m_ready) w_state_nxt = ST_CLEAR;
      default:    w_state_nxt = ST_CLEAR;
    endcase
  end

  // Idle cycles feed zero, which never displaces a tracked value.
  always_comb begin
    w_pop        = 1'b0;
    w_trk_din    = '0;
    w_trk_resetn = 1'b1;
    w_m_valid    = 1'b0;
    w_cnt_clr    = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_trk_resetn = 1'b0;
        w_cnt_clr    = 1'b1;
      end
      ST_STREAM: begin
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_trk_din = DATA_WIDTH'(w_head_ent.data);
        end
      end
      ST_CAPTURE: w_capture = 1'b1;
      ST_REPORT:  w_m_valid = 1'b1;
      default:    w_trk_resetn = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_m_count <= '0;
    end else if (w_cnt_clr) begin
      r_m_count <= '0;
    end else if (w_pop && (r_m_count != '1)) begin
      r_m_count <= r_m_count + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        r_m_data <= '0;
    else if (w_capture) r_m_data <= trk_dout;
  end

  assign trk_din    = w_trk_din;
  assign trk_resetn = w_trk_resetn;
  assign m_valid    = w_m_valid;
  assign m_data     = r_m_data;
  assign m_count    = r_m_count;

endmodule : frame_feeder
`default_nettype wire

// File: doc/frame_feeder.md
FRAME_FEEDER -- requirements
Module: frame_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 32: sample width; SHALL match the downstream second-largest tracker.
REQ-002 Parameter FIFO_DEPTH, default 4: input FIFO entries; SHALL be a power of two and at least 2.
REQ-003 Parameter COUNT_WIDTH, default 16: width of the per-frame sample counter.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 s_valid / s_ready / s_data[DATA_WIDTH] / s_last  in/out/in/in  input sample stream; s_last marks the final sample of a frame.
REQ-007 trk_din  out  DATA_WIDTH  sample presented to the tracker every cycle.
REQ-008 trk_resetn  out  1  synchronous active-low clear to the tracker.
REQ-009 trk_dout  in  DATA_WIDTH  tracker's registered second-largest value.
REQ-010 m_valid / m_ready / m_data[DATA_WIDTH] / m_count[COUNT_WIDTH]  out/in/out/out  per-frame result: second-largest value and sample count.

Function
REQ-011 Input accept: a push SHALL occur when s_valid && s_ready; s_ready SHALL equal !fifo_full, with no same-cycle pop bypass when full.
REQ-012 FIFO entries SHALL store {s_last, s_data}; pointers SHALL wrap modulo FIFO_DEPTH; an occupancy counter of log2(FIFO_DEPTH)+1 bits SHALL derive full and empty.
REQ-013 FSM states: CLEAR, STREAM, CAPTURE, REPORT.
REQ-014 CLEAR: trk_resetn=0, trk_din=0, m_count cleared; no pop; next state STREAM.
REQ-015 STREAM: if FIFO non-empty, pop the head, drive trk_din=head data, and increment m_count, saturating at all-ones; if head carries last, next state CAPTURE.
REQ-016 STREAM with FIFO empty: trk_din=0, no pop, stay. A zero bubble never changes the tracker's second-largest result.
REQ-017 CAPTURE: trk_din=0; register trk_dout into m_data; next state REPORT.
REQ-018 REPORT: m_valid=1, trk_din=0; m_data and m_count SHALL be held stable; on m_ready, next state CLEAR.
REQ-019 Latency: m_valid SHALL rise exactly 2 cycles after the pop cycle of the last-flagged sample.
REQ-020 Outside CLEAR, trk_resetn SHALL be 1; m_valid SHALL be 1 only in REPORT.
REQ-021 During CAPTURE, REPORT and CLEAR, the FIFO SHALL keep accepting pushes up to full.
REQ-022 Minimum frame-to-frame gap: the first pop of frame N+1 SHALL occur no earlier than the cycle after CLEAR.

Reset
REQ-023 On resetn low, the block SHALL asynchronously empty the FIFO, enter CLEAR, and zero m_data, m_count and m_valid.
REQ-024 While resetn is low, s_ready SHALL be 0 and trk_resetn SHALL be 0.
REQ-025 After resetn deasserts, the block SHALL spend exactly one cycle in CLEAR before entering STREAM.
REQ-026 Reset mid-frame SHALL discard all partial-frame samples and produce no m_valid for that frame.

Structure
REQ-027 A shared package frame_feeder_pkg SHALL hold the FSM state enum and the FIFO entry struct {last, data}.
REQ-028 The FIFO SHALL be a sub-module named frame_fifo (parameters DATA_WIDTH+1 and FIFO_DEPTH), with push, pop, full, empty and head outputs.
REQ-029 The FSM, counter and result registers SHALL reside in frame_feeder.

Verification
REQ-030 Frame 3,7,5(last), m_ready=1 -> m_data=5, m_count=3, m_valid high 2 cycles after the pop of 5, then 1 cycle of trk_resetn=0.
REQ-031 Single-sample frame 9(last) -> m_data=0, m_count=1.
REQ-032 Duplicates 4,4,1(last) -> m_data=4, m_count=3; next frame 2,1(last) -> m_data=1 with no carry-over.
REQ-033 m_ready held low 10 cycles in REPORT while 6 samples are offered -> s_ready drops after 4 pushes, m_data stays constant, and all 6 samples are delivered in order after release.
REQ-034 s_valid gaps of 3 cycles between samples 8,2,6(last) -> trk_din=0 during gaps, m_data=6, m_count=3.
REQ-035 resetn pulsed low after 2 of 4 samples -> no m_valid; the next frame 1,10(last) -> m_data=1, m_count=2.
